// File: rtl/host_link_master.sv
// host_link_master: initiator side of the toggle-sync CPLD host link.
// Optional timeout/recover path is built when HOST_LINK_TIMEOUT_EN is defined.
module host_link_master #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [3:0] i_req_cmd,
  input  logic [7:0] i_req_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_timeout,
  output logic       o_link_en,
  output logic       o_link_sync,
  output logic [3:0] o_link_cmd,
  output logic [7:0] o_link_data,
  input  logic       i_link_sync,
  input  logic [7:0] i_link_data
);

`ifdef HOST_LINK_TIMEOUT_EN
  localparam int unsigned CNT_MAX =
    (TIMEOUT > SETUP_CYCLES) ? TIMEOUT : SETUP_CYCLES;
`else
  localparam int unsigned CNT_MAX = SETUP_CYCLES;
`endif
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
`ifdef HOST_LINK_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_ECHO,
    CAPTURE
`ifdef HOST_LINK_TIMEOUT_EN
    , RECOVER
`endif
  } state_e;

  state_e state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic ready_d, ready_q;
  logic en_d, en_q;
  logic sync_d, sync_q;
  logic [3:0] cmd_d, cmd_q;
  logic [7:0] ldata_d, ldata_q;
  logic rsp_valid_d, rsp_valid_q;
  logic [7:0] rsp_data_d, rsp_data_q;
  logic [SYNC_STAGES-1:0] ssync_d, ssync_q;
  logic [SYNC_STAGES-1:0][7:0] sdata_d, sdata_q;
  logic echo;
  logic [7:0] echo_data;

`ifdef HOST_LINK_TIMEOUT_EN
  logic timeout_d, timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Synchronizer chains for the asynchronous echo and response byte
  always_comb begin
    ssync_d = {ssync_q[SYNC_STAGES-2:0], i_link_sync};
    sdata_d = {sdata_q[SYNC_STAGES-2:0], i_link_data};
  end

  assign echo      = ssync_q[SYNC_STAGES-1];
  assign echo_data = sdata_q[SYNC_STAGES-1];

  // Transaction sequencing: next state and registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = 1'b1;
    sync_d      = sync_q;
    cmd_d       = cmd_q;
    ldata_d     = ldata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef HOST_LINK_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req_valid && ready_q) begin
          state_d = SETUP;
          cmd_d   = i_req_cmd;
          ldata_d = i_req_data;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          sync_d  = ~sync_q;
          cnt_d   = '0;
          state_d = WAIT_ECHO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_ECHO: begin
        if (echo == sync_q) begin
          state_d = CAPTURE;
`ifdef HOST_LINK_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d     = RECOVER;
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b1;
          en_d        = 1'b0;
          sync_d      = 1'b0;
          cnt_d       = '0;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      CAPTURE: begin
        rsp_data_d  = echo_data;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
`ifdef HOST_LINK_TIMEOUT_EN
      RECOVER: begin
        en_d   = 1'b0;
        sync_d = 1'b0;
        if (cnt_q == CW'(1)) begin
          en_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset parks the link with enable low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      sync_q      <= 1'b0;
      cmd_q       <= '0;
      ldata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ssync_q     <= '0;
      sdata_q     <= '0;
`ifdef HOST_LINK_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      en_q        <= en_d;
      sync_q      <= sync_d;
      cmd_q       <= cmd_d;
      ldata_q     <= ldata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ssync_q     <= ssync_d;
      sdata_q     <= sdata_d;
`ifdef HOST_LINK_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_link_en   = en_q;
  assign o_link_sync = sync_q;
  assign o_link_cmd  = cmd_q;
  assign o_link_data = ldata_q;
`ifdef HOST_LINK_TIMEOUT_EN
  assign o_rsp_timeout = timeout_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_host_link_master.sv
// tb_host_link_master: randomized bench with a behavioural CPLD responder.
// Define HOST_LINK_TIMEOUT_EN to also exercise the timeout/recover path.
module tb_host_link_master;
  localparam int SETUP = 2;
  localparam int SYNC  = 2;
  localparam int TO    = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst = 1'b1;
  logic       i_req_valid = 1'b0;
  logic [3:0] i_req_cmd = '0;
  logic [7:0] i_req_data = '0;
  logic       o_req_ready, o_rsp_valid, o_rsp_timeout;
  logic [7:0] o_rsp_data;
  logic       o_link_en, o_link_sync;
  logic [3:0] o_link_cmd;
  logic [7:0] o_link_data;
  logic       m_sync = 1'b0;
  logic [7:0] m_data = '0;

  host_link_master #(
    .SETUP_CYCLES(SETUP), .SYNC_STAGES(SYNC), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_cmd(i_req_cmd), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_rsp_timeout(o_rsp_timeout),
    .o_link_en(o_link_en), .o_link_sync(o_link_sync),
    .o_link_cmd(o_link_cmd), .o_link_data(o_link_data),
    .i_link_sync(m_sync), .i_link_data(m_data)
  );

  int total = 0;
  int bad = 0;
  int rsp_cnt = 0;
  logic exp_sync = 1'b0;
  logic [7:0] last_rsp = '0;

  // CPLD responder: echoes a new sync m_delay cycles after it appears
  int m_delay = 3;
  bit m_silent = 1'b0;
  logic [7:0] m_next = 8'h5A;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (o_link_en !== 1'b1) begin
      m_sync <= 1'b0;
      m_cnt  <= 0;
    end else if (o_link_sync !== m_sync && !m_silent) begin
      if (m_cnt >= m_delay - 1) begin
        m_sync <= o_link_sync;
        m_data <= m_next;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) if (o_rsp_valid === 1'b1) rsp_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Presents one request, then watches the link until a response or maxc cycles
  task automatic issue(input logic [3:0] cmd, input logic [7:0] dat,
                       input int maxc, output int acc, output int lat,
                       output int tog, output bit stable);
    bit rdy;
    logic s0;
    i_req_valid = 1'b1;
    i_req_cmd   = cmd;
    i_req_data  = dat;
    acc = 0;
    do begin
      rdy = o_req_ready;
      @(posedge clk); #1;
      acc++;
    end while (!rdy && acc < 50);
    i_req_valid = 1'b0;
    i_req_cmd   = 4'($urandom);
    i_req_data  = 8'($urandom);
    lat = -1;
    tog = -1;
    stable = rdy;
    s0 = o_link_sync;
    if (o_link_cmd !== cmd || o_link_data !== dat) stable = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk); #1;
      if (tog < 0 && o_link_sync !== s0) tog = k;
      if (o_link_cmd !== cmd || o_link_data !== dat) stable = 1'b0;
      if (o_rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if ({o_link_en, o_link_sync, o_link_cmd, o_link_data, o_req_ready,
           o_rsp_valid, o_rsp_data, o_rsp_timeout} !== 27'd0) begin
        bad++;
        $display("FAIL reset_outputs got en=%b sync=%b cmd=%h data=%h rdy=%b v=%b rd=%h to=%b exp all 0",
                 o_link_en, o_link_sync, o_link_cmd, o_link_data,
                 o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_timeout);
      end
    end
    i_rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (o_link_en !== 1'b1) begin
      bad++; $display("FAIL reset_release_en got=%b exp=1", o_link_en);
    end
    total++;
    if (o_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got=%b exp=1", o_req_ready);
    end
    exp_sync = 1'b0;
    last_rsp = 8'h00;
  endtask

  task automatic test_read();
    int acc, lat, tog;
    bit st;
    m_delay = 3;
    m_next  = 8'h5A;
    issue(4'b0001, 8'($urandom), 100, acc, lat, tog, st);
    exp_sync = ~exp_sync;
    last_rsp = 8'h5A;
    total++;
    if (lat !== SETUP + SYNC + 2 + 3) begin
      bad++; $display("FAIL read_latency got=%0d exp=%0d", lat, SETUP + SYNC + 5);
    end
    total++;
    if (tog !== SETUP) begin
      bad++; $display("FAIL read_setup got=%0d exp=%0d", tog, SETUP);
    end
    total++;
    if (!st) begin
      bad++; $display("FAIL read_cmd_stable got=0 exp=1");
    end
    total++;
    if (o_rsp_data !== 8'h5A || o_rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL read_rsp got=%h/%b exp=5a/0", o_rsp_data, o_rsp_timeout);
    end
    total++;
    if (o_link_sync !== exp_sync) begin
      bad++; $display("FAIL read_sync got=%b exp=%b", o_link_sync, exp_sync);
    end
    @(posedge clk); #1;
    total++;
    if (o_rsp_valid !== 1'b0 || o_rsp_data !== 8'h5A) begin
      bad++; $display("FAIL read_pulse_once got=%b/%h exp=0/5a", o_rsp_valid, o_rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    int acc, lat, tog, c0;
    bit st;
    logic [3:0] c2;
    logic [7:0] d2;
    c0 = rsp_cnt;
    m_delay = 3;
    m_next  = 8'h5A;
    issue(4'b1011, 8'hC3, 100, acc, lat, tog, st);
    exp_sync = ~exp_sync;
    total++;
    if (lat !== SETUP + SYNC + 5 || !st) begin
      bad++; $display("FAIL b2b_first got lat=%0d stable=%0d exp lat=%0d stable=1",
                      lat, st, SETUP + SYNC + 5);
    end
    total++;
    if (o_link_sync !== exp_sync) begin
      bad++; $display("FAIL b2b_first_sync got=%b exp=%b", o_link_sync, exp_sync);
    end
    c2 = 4'($urandom);
    d2 = 8'($urandom);
    m_next = 8'($urandom);
    issue(c2, d2, 100, acc, lat, tog, st);
    exp_sync = ~exp_sync;
    last_rsp = m_next;
    total++;
    if (acc !== 1) begin
      bad++; $display("FAIL b2b_accept_cycles got=%0d exp=1", acc);
    end
    total++;
    if (lat !== SETUP + SYNC + 5 || !st || o_rsp_data !== m_next) begin
      bad++; $display("FAIL b2b_second got lat=%0d stable=%0d data=%h exp lat=%0d stable=1 data=%h",
                      lat, st, o_rsp_data, SETUP + SYNC + 5, m_next);
    end
    total++;
    if (o_link_sync !== exp_sync) begin
      bad++; $display("FAIL b2b_second_sync got=%b exp=%b", o_link_sync, exp_sync);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_cnt - c0 !== 2) begin
      bad++; $display("FAIL b2b_pulses got=%0d exp=2", rsp_cnt - c0);
    end
  endtask

  task automatic test_stale_echo();
    int acc, lat, tog;
    bit st;
    m_delay = 10;
    m_next  = 8'hA7;
    issue(4'b0001, 8'h00, 100, acc, lat, tog, st);
    exp_sync = ~exp_sync;
    last_rsp = 8'hA7;
    total++;
    if (lat !== SETUP + SYNC + 2 + 10 || tog !== SETUP) begin
      bad++; $display("FAIL stale_echo got lat=%0d tog=%0d exp lat=%0d tog=%0d",
                      lat, tog, SETUP + SYNC + 12, SETUP);
    end
    total++;
    if (o_rsp_data !== 8'hA7) begin
      bad++; $display("FAIL stale_echo_data got=%h exp=a7", o_rsp_data);
    end
  endtask

  task automatic test_random();
    int acc, lat, tog, d, gap;
    bit st;
    logic [3:0] c;
    logic [7:0] dat;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 2))
        0: c = 4'b0000;
        1: c = 4'b0001;
        default: c = {1'b1, 3'($urandom)};
      endcase
      dat = 8'($urandom);
      d = $urandom_range(1, 8);
      m_delay = d;
      m_next = 8'($urandom);
      issue(c, dat, 100, acc, lat, tog, st);
      exp_sync = ~exp_sync;
      last_rsp = m_next;
      total++;
      if (lat !== SETUP + SYNC + 2 + d || tog !== SETUP || !st) begin
        bad++; $display("FAIL rand%0d_timing got lat=%0d tog=%0d stable=%0d exp lat=%0d tog=%0d stable=1",
                        n, lat, tog, st, SETUP + SYNC + 2 + d, SETUP);
      end
      total++;
      if (o_rsp_data !== last_rsp || o_rsp_timeout !== 1'b0 ||
          o_link_sync !== exp_sync) begin
        bad++; $display("FAIL rand%0d_rsp got data=%h to=%b sync=%b exp data=%h to=0 sync=%b",
                        n, o_rsp_data, o_rsp_timeout, o_link_sync, last_rsp, exp_sync);
      end
      gap = $urandom_range(1, 3);
      repeat (gap) begin @(posedge clk); #1; end
      total++;
      if (o_rsp_data !== last_rsp || o_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL rand%0d_hold got data=%h v=%b exp data=%h v=0",
                        n, o_rsp_data, o_rsp_valid, last_rsp);
      end
    end
  endtask

`ifdef HOST_LINK_TIMEOUT_EN
  task automatic test_timeout();
    int acc, lat, tog;
    bit st;
    m_silent = 1'b1;
    issue(4'b0001, 8'h11, 100, acc, lat, tog, st);
    total++;
    if (lat !== SETUP + TO || o_rsp_timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_pulse got lat=%0d to=%b exp lat=%0d to=1",
                      lat, o_rsp_timeout, SETUP + TO);
    end
    total++;
    if (o_rsp_data !== last_rsp || o_link_en !== 1'b0 || o_link_sync !== 1'b0) begin
      bad++; $display("FAIL timeout_state got data=%h en=%b sync=%b exp data=%h en=0 sync=0",
                      o_rsp_data, o_link_en, o_link_sync, last_rsp);
    end
    @(posedge clk); #1;
    total++;
    if (o_link_en !== 1'b0 || o_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_recover got en=%b v=%b exp en=0 v=0", o_link_en, o_rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (o_link_en !== 1'b1 || o_req_ready !== 1'b1) begin
      bad++; $display("FAIL timeout_idle got en=%b rdy=%b exp 1/1", o_link_en, o_req_ready);
    end
    m_silent = 1'b0;
    exp_sync = 1'b0;
    m_delay = 3;
    m_next = 8'h3C;
    issue(4'b1001, 8'h77, 100, acc, lat, tog, st);
    exp_sync = ~exp_sync;
    last_rsp = 8'h3C;
    total++;
    if (lat !== SETUP + SYNC + 5 || o_rsp_timeout !== 1'b0 ||
        o_rsp_data !== 8'h3C || o_link_sync !== exp_sync) begin
      bad++; $display("FAIL timeout_next got lat=%0d to=%b data=%h sync=%b exp lat=%0d to=0 data=3c sync=%b",
                      lat, o_rsp_timeout, o_rsp_data, o_link_sync, SETUP + SYNC + 5, exp_sync);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int acc, lat, tog, c0;
    bit st;
    m_delay = 20;
    m_next = 8'hEE;
    c0 = rsp_cnt;
    issue(4'b0001, 8'h00, 6, acc, lat, tog, st);
    total++;
    if (lat !== -1 || o_link_sync !== ~exp_sync) begin
      bad++; $display("FAIL midrst_pre got lat=%0d sync=%b exp lat=-1 sync=%b",
                      lat, o_link_sync, ~exp_sync);
    end
    i_rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({o_link_en, o_link_sync, o_link_cmd, o_link_data, o_req_ready,
         o_rsp_valid, o_rsp_data, o_rsp_timeout} !== 27'd0) begin
      bad++; $display("FAIL midrst_outputs got en=%b sync=%b cmd=%h data=%h rdy=%b v=%b rd=%h exp all 0",
                      o_link_en, o_link_sync, o_link_cmd, o_link_data,
                      o_req_ready, o_rsp_valid, o_rsp_data);
    end
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(posedge clk); #1;
    exp_sync = 1'b0;
    last_rsp = 8'h00;
    total++;
    if (o_link_en !== 1'b1 || o_req_ready !== 1'b1 || o_link_sync !== 1'b0) begin
      bad++; $display("FAIL midrst_release got en=%b rdy=%b sync=%b exp 1/1/0",
                      o_link_en, o_req_ready, o_link_sync);
    end
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (rsp_cnt !== c0) begin
      bad++; $display("FAIL midrst_no_rsp got=%0d exp=%0d", rsp_cnt - c0, 0);
    end
    m_delay = 3;
    m_next = 8'h5A;
    issue(4'b0001, 8'h00, 100, acc, lat, tog, st);
    exp_sync = ~exp_sync;
    total++;
    if (lat !== SETUP + SYNC + 5 || o_rsp_data !== 8'h5A || o_link_sync !== exp_sync) begin
      bad++; $display("FAIL midrst_after got lat=%0d data=%h sync=%b exp lat=%0d data=5a sync=%b",
                      lat, o_rsp_data, o_link_sync, SETUP + SYNC + 5, exp_sync);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_stale_echo();
    test_random();
`ifdef HOST_LINK_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
